// File: rtl/l2cache_dirty_tracker_if.sv
// Bus bundle between the L2 control/write-back logic and the dirty-bit tracker.
// The tracker uses the slave view; the L2 control side uses the master view.
interface l2cache_dirty_tracker_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int WAY        = 8,
   parameter int WAY_BITS   = $clog2(WAY)
);
   logic                  init_busy;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WAY-1:0]        rd_dirty;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WAY_BITS-1:0]   wr_way;
   logic                  wr_set1;
   logic                  wr_set0;
   logic                  scan_start;
   logic                  scan_busy;
   logic                  scan_valid;
   logic                  scan_ready;
   logic [ADDR_WIDTH-1:0] scan_set;
   logic [WAY_BITS-1:0]   scan_way;
   logic                  scan_done;

   modport slave (
      input  rd_addr, wr_addr, wr_way, wr_set1, wr_set0, scan_start, scan_ready,
      output init_busy, rd_dirty, scan_busy, scan_valid, scan_set, scan_way, scan_done
   );

   modport master (
      output rd_addr, wr_addr, wr_way, wr_set1, wr_set0, scan_start, scan_ready,
      input  init_busy, rd_dirty, scan_busy, scan_valid, scan_set, scan_way, scan_done
   );
endinterface

// File: rtl/l2cache_dirty_tracker.sv
// Per-set dirty-bit store for the L2 with a post-reset clear sweep and a flush
// scanner that hands every dirty line to the write-back logic over valid/ready.
//
// state     | meaning
// S_INIT    | clearing word[ptr] each cycle after reset; writes/scan_start ignored
// S_IDLE    | normal read/write service, waiting for scan_start
// S_SCAN    | inspecting word[ptr]; advance if clean, capture lowest dirty way otherwise
// S_PRESENT | scan_set/scan_way offered to the consumer until accepted
// S_DONE    | one-cycle scan_done pulse
module l2cache_dirty_tracker #(
   parameter int ADDR_WIDTH   = 4,
   parameter int WAY          = 8,
   parameter int WAY_BITS     = $clog2(WAY),
   parameter int SCAN_AUTOCLR = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   l2cache_dirty_tracker_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_PRESENT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] sset_q, sset_d;
   logic [WAY_BITS-1:0]   sway_q, sway_d;
   logic [WAY-1:0]        rd_q, rd_d;
   logic [WAY-1:0]        mem [DEPTH];
   logic [WAY-1:0]        scan_word;
   logic [WAY-1:0]        rd_word;
   logic [WAY_BITS-1:0]   low_way;
   logic                  wr_en;
   logic                  accept;
   logic                  aclr;

   assign wr_en  = (state_q != S_INIT) && (bus.wr_set1 || bus.wr_set0) && (32'(bus.wr_way) < WAY);
   assign accept = (state_q == S_PRESENT) && bus.scan_ready;
   assign aclr   = accept && (SCAN_AUTOCLR != 0);

   assign scan_word = mem[ptr_q];

   always_comb begin
      low_way = '0;
      for (int i = WAY - 1; i >= 0; i--) begin
         if (scan_word[i]) low_way = WAY_BITS'(i);
      end
   end

   // Write-first read: fold this cycle's auto-clear and external write into the
   // word being registered, external write applied last so set1 beats auto-clear.
   always_comb begin
      rd_word = mem[bus.rd_addr];
      if (aclr && (sset_q == bus.rd_addr)) rd_word[sway_q] = 1'b0;
      if (wr_en && (bus.wr_addr == bus.rd_addr)) rd_word[bus.wr_way] = bus.wr_set1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_INIT) begin
            mem[ptr_q] <= '0;
         end else begin
            if (aclr)  mem[sset_q][sway_q] <= 1'b0;
            if (wr_en) mem[bus.wr_addr][bus.wr_way] <= bus.wr_set1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
         sset_q  <= '0;
         sway_q  <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sset_q  <= sset_d;
         sway_q  <= sway_d;
         rd_q    <= rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sset_d  = sset_q;
      sway_d  = sway_q;
      rd_d    = (state_q == S_INIT) ? '0 : rd_word;
      case (state_q)
         S_INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (bus.scan_start) begin
               state_d = S_SCAN;
               ptr_d   = '0;
            end
         end
         S_SCAN: begin
            if (scan_word != '0) begin
               sset_d  = ptr_q;
               sway_d  = low_way;
               state_d = S_PRESENT;
            end else if (ptr_q == LAST) begin
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         S_PRESENT: begin
            // Same set is rescanned after accept so remaining ways are found.
            if (bus.scan_ready) state_d = S_SCAN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   assign bus.init_busy  = rst || (state_q == S_INIT);
   assign bus.rd_dirty   = rst ? '0 : rd_q;
   assign bus.scan_busy  = !rst && ((state_q == S_SCAN) || (state_q == S_PRESENT) || (state_q == S_DONE));
   assign bus.scan_valid = !rst && (state_q == S_PRESENT);
   assign bus.scan_done  = !rst && (state_q == S_DONE);
   assign bus.scan_set   = rst ? '0 : sset_q;
   assign bus.scan_way   = rst ? '0 : sway_q;
endmodule

// File: tb/tb_l2cache_dirty_tracker.sv
// Randomized bench for l2cache_dirty_tracker against an array-based dirty-bit model
// with an ordered list of expected flush hand-overs.
module tb_l2cache_dirty_tracker;
   localparam int AW    = 4;
   localparam int NW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2cache_dirty_tracker_if #(.ADDR_WIDTH(AW), .WAY(NW)) bus();

   l2cache_dirty_tracker #(.ADDR_WIDTH(AW), .WAY(NW), .SCAN_AUTOCLR(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [NW-1:0] ref_mem [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.rd_addr    = '0;
      bus.wr_addr    = '0;
      bus.wr_way     = '0;
      bus.wr_set1    = 1'b0;
      bus.wr_set0    = 1'b0;
      bus.scan_start = 1'b0;
      bus.scan_ready = 1'b0;
   endtask

   task automatic model_wr(input int a, input int w, input logic s1, input logic s0);
      if (w < NW) begin
         if (s1)      ref_mem[a][w] = 1'b1;
         else if (s0) ref_mem[a][w] = 1'b0;
      end
   endtask

   task automatic do_reset(input int hold);
      int   cnt;
      logic done_seen;
      logic rd_seen;
      rst = 1'b1;
      idle_inputs();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rst_init_busy", 32'(bus.init_busy), 1);
         check("rst_rd_dirty", 32'(bus.rd_dirty), 0);
         check("rst_scan_flags", {bus.scan_valid, bus.scan_busy, bus.scan_done}, 0);
         check("rst_scan_line", {bus.scan_set, bus.scan_way}, 0);
      end
      rst = 1'b0;
      for (int s = 0; s < DEPTH; s++) ref_mem[s] = '0;
      cnt = 0;
      done_seen = 1'b0;
      rd_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus.init_busy) break;
         cnt++;
         done_seen = done_seen | bus.scan_done;
         rd_seen = rd_seen | (bus.rd_dirty != '0);
         @(negedge clk);
      end
      check("init_len", cnt, 16);
      check("init_no_done", 32'(done_seen), 0);
      check("init_rd_zero", 32'(rd_seen), 0);
   endtask

   task automatic write_line(input int a, input int w, input logic s1, input logic s0);
      bus.wr_addr = AW'(a);
      bus.wr_way  = 3'(w);
      bus.wr_set1 = s1;
      bus.wr_set0 = s0;
      model_wr(a, w, s1, s0);
      @(negedge clk);
      bus.wr_set1 = 1'b0;
      bus.wr_set0 = 1'b0;
   endtask

   task automatic read_check(input string tag, input int a);
      bus.rd_addr = AW'(a);
      @(negedge clk);
      check(tag, 32'(bus.rd_dirty), 32'(ref_mem[a]));
   endtask

   task automatic read_sweep(input string tag);
      for (int s = 0; s < DEPTH; s++) read_check(tag, s);
   endtask

   // mode 0: always ready; 1: random ready and read address; 2: stall first line
   // for 5 cycles; 3: always ready with writes to sets 3 and 12 mid-scan.
   task automatic run_scan(input int mode);
      int   qs[$];
      int   qw[$];
      int   dones;
      int   stall;
      int   ra;
      logic prev_stall;
      logic [AW-1:0] pset;
      logic [2:0]    pway;
      logic [NW-1:0] exp_rd;
      logic rdy;
      dones = 0;
      stall = 0;
      prev_stall = 1'b0;
      pset = '0;
      pway = '0;
      for (int s = 0; s < DEPTH; s++)
         for (int w = 0; w < NW; w++)
            if (ref_mem[s][w]) begin
               qs.push_back(s);
               qw.push_back(w);
            end
      ra = (mode == 2 && qs.size() > 0) ? qs[0] : 0;
      bus.rd_addr = AW'(ra);
      exp_rd = ref_mem[ra];
      bus.scan_start = 1'b1;
      bus.scan_ready = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         bus.scan_start = 1'b0;
         bus.wr_set1 = 1'b0;
         bus.wr_set0 = 1'b0;
         check("scan_rd", 32'(bus.rd_dirty), 32'(exp_rd));
         if (bus.scan_done) begin
            dones++;
            break;
         end
         if (prev_stall)
            check("scan_hold", {bus.scan_valid, bus.scan_set, bus.scan_way}, {1'b1, pset, pway});
         case (mode)
            1:       rdy = 1'($urandom % 2);
            2:       rdy = (stall >= 5);
            default: rdy = 1'b1;
         endcase
         bus.scan_ready = rdy;
         prev_stall = 1'b0;
         if (bus.scan_valid) begin
            if (rdy) begin
               check("scan_qlen", 32'(qs.size() > 0), 1);
               if (qs.size() > 0) begin
                  check("scan_line", int'(bus.scan_set) * 8 + int'(bus.scan_way), qs[0] * 8 + qw[0]);
                  ref_mem[qs[0]][qw[0]] = 1'b0;
                  void'(qs.pop_front());
                  void'(qw.pop_front());
               end
            end else begin
               prev_stall = 1'b1;
               pset = bus.scan_set;
               pway = bus.scan_way;
               stall++;
            end
         end
         if (mode == 3 && cyc == 6) begin
            bus.wr_addr = 4'd3; bus.wr_way = 3'd0; bus.wr_set1 = 1'b1;
            model_wr(3, 0, 1'b1, 1'b0);
         end
         if (mode == 3 && cyc == 7) begin
            bus.wr_addr = 4'd12; bus.wr_way = 3'd2; bus.wr_set1 = 1'b1;
            model_wr(12, 2, 1'b1, 1'b0);
            qs.push_back(12);
            qw.push_back(2);
         end
         if (mode == 1) ra = int'($urandom % DEPTH);
         bus.rd_addr = AW'(ra);
         exp_rd = ref_mem[ra];
      end
      check("scan_done_cnt", dones, 1);
      check("scan_left", qs.size(), 0);
      bus.scan_ready = 1'b0;
      @(negedge clk);
      check("scan_idle", {bus.scan_busy, bus.scan_done}, 0);
   endtask

   initial begin
      logic [NW-1:0] exp_rd;
      logic seen;
      int ra;
      int wa;
      rst = 1'b1;
      idle_inputs();

      // T1: reset and sweep
      do_reset(3);
      read_sweep("t1_clean");

      // T2: basic set/clear and set1 priority
      write_line(5, 3, 1'b1, 1'b0);
      read_check("t2_set1", 5);
      check("t2_set1_val", 32'(bus.rd_dirty), 32'h08);
      write_line(5, 3, 1'b1, 1'b1);
      read_check("t2_both", 5);
      check("t2_both_val", 32'(bus.rd_dirty), 32'h08);
      write_line(5, 3, 1'b0, 1'b1);
      read_check("t2_set0", 5);
      check("t2_set0_val", 32'(bus.rd_dirty), 32'h00);

      // T3: same-cycle write/read forwarding
      bus.rd_addr = 4'd7;
      write_line(7, 0, 1'b1, 1'b0);
      check("t3_fwd", 32'(bus.rd_dirty), 32'h01);

      // random read/write traffic
      bus.rd_addr = '0;
      exp_rd = ref_mem[0];
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         check("rw_rand", 32'(bus.rd_dirty), 32'(exp_rd));
         ra = int'($urandom % DEPTH);
         wa = ($urandom % 4 == 0) ? ra : int'($urandom % DEPTH);
         bus.rd_addr = AW'(ra);
         bus.wr_addr = AW'(wa);
         bus.wr_way  = 3'($urandom % NW);
         bus.wr_set1 = 1'($urandom % 2);
         bus.wr_set0 = 1'($urandom % 2);
         model_wr(wa, int'(bus.wr_way), bus.wr_set1, bus.wr_set0);
         exp_rd = ref_mem[ra];
      end
      @(negedge clk);
      check("rw_rand", 32'(bus.rd_dirty), 32'(exp_rd));
      bus.wr_set1 = 1'b0;
      bus.wr_set0 = 1'b0;

      // drain the random content with a randomly back-pressured flush
      run_scan(1);
      read_sweep("drain_clean");

      // T4: directed flush order
      write_line(2, 6, 1'b1, 1'b0);
      write_line(2, 1, 1'b1, 1'b0);
      write_line(15, 7, 1'b1, 1'b0);
      run_scan(0);
      read_sweep("t4_clean");

      // T5: backpressure on the first presented line
      write_line(9, 4, 1'b1, 1'b0);
      write_line(11, 2, 1'b1, 1'b0);
      run_scan(2);
      read_sweep("t5_clean");

      // T6: writes racing the scan pointer
      run_scan(3);
      read_check("t6_set3", 3);
      check("t6_set3_val", 32'(bus.rd_dirty), 32'h01);
      read_check("t6_set12", 12);
      check("t6_set12_val", 32'(bus.rd_dirty), 32'h00);

      // T6: reset while a line is presented
      bus.scan_start = 1'b1;
      bus.scan_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus.scan_start = 1'b0;
         if (bus.scan_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_present", 32'(seen), 1);
      check("t6_line", {bus.scan_set, bus.scan_way}, {4'd3, 3'd0});
      do_reset(2);
      read_sweep("t6_post_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
